fft_stream_collector: RTL and testbench

//  Receive end of the FFT processor's serial output: captures the 8 real/imag words that the

---
 rtl/fft_stream_collector_pkg.sv | 24 ++
 rtl/fft_frame_bank.sv | 46 ++++
 rtl/fft_stream_collector.sv | 147 ++++++++++++++
 tb/tb_fft_stream_collector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_collector_pkg.sv
// ============================================================================
// Module : fft_stream_collector_pkg
// Brief  : Shared defaults and state encodings for the FFT stream collector
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_stream_collector_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int NPOINT_DEF = 8;
    localparam int AW_DEF     = 3;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_COMMIT  = 2'd2;
    localparam logic [1:0] c_ST_DROP    = 2'd3;

    localparam logic c_BANK_EMPTY = 1'b0;
    localparam logic c_BANK_FULL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fft_frame_bank.sv
// ============================================================================
// Module : fft_frame_bank
// Brief  : Two-bank frame store, one write port, one registered read port
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_frame_bank #(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 8,
    parameter int AW     = 3
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic                 i_wr_bank,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [2*WIDTH-1:0]   i_wr_data,
    input  logic                 i_rd_bank,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [2*WIDTH-1:0]   o_rd_data
);

    // Storage is intentionally never reset; only the read register is.
    logic [2*WIDTH-1:0] r_mem [2*NPOINT];
    logic [2*WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fft_stream_collector.sv
// ============================================================================
// Module : fft_stream_collector
// Brief  : Collects serial FFT output words into ping-pong frame banks
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_stream_collector
    import fft_stream_collector_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NPOINT  = NPOINT_DEF,
    parameter int AW      = AW_DEF,
    parameter int REVERSE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_release,
    output logic [WIDTH-1:0] rd_re,
    output logic [WIDTH-1:0] rd_im,
    output logic             frame_ready,
    output logic             frame_done,
    output logic             busy,
    output logic             overflow,
    output logic             short_err
);

    logic [1:0]          r_state;
    logic [AW-1:0]       r_cnt;
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                r_overflow;
    logic                r_short_err;

    logic                w_last;
    logic                w_tgt_bank;
    logic                w_start;
    logic                w_start_ok;
    logic                w_wr_en;
    logic [AW-1:0]       w_waddr;
    logic                w_release;
    logic [2*WIDTH-1:0]  w_rd_data;

    assign w_last = (r_cnt == AW'(NPOINT - 1));

    // During COMMIT the pointer has not toggled yet, so a back-to-back frame
    // must target the other bank.
    assign w_tgt_bank = (r_state == c_ST_COMMIT) ? ~r_wr_bank : r_wr_bank;
    assign w_start    = in_valid && ((r_state == c_ST_IDLE) || (r_state == c_ST_COMMIT));
    assign w_start_ok = w_start && (r_full[w_tgt_bank] == c_BANK_EMPTY);
    assign w_wr_en    = w_start_ok || ((r_state == c_ST_CAPTURE) && in_valid);
    assign w_waddr    = (REVERSE != 0) ? (AW'(NPOINT - 1) - r_cnt) : r_cnt;
    assign w_release  = rd_release && (r_full[r_rd_bank] == c_BANK_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_full      <= {c_BANK_EMPTY, c_BANK_EMPTY};
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_overflow  <= 1'b0;
            r_short_err <= 1'b0;
        end else begin
            if (w_release) begin
                r_full[r_rd_bank] <= c_BANK_EMPTY;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (r_state == c_ST_COMMIT) begin
                r_full[r_wr_bank] <= c_BANK_FULL;
                r_wr_bank         <= ~r_wr_bank;
            end
            case (r_state)
                c_ST_IDLE, c_ST_COMMIT: begin
                    if (in_valid) begin
                        r_cnt <= AW'(1);
                        if (w_start_ok) begin
                            r_state <= c_ST_CAPTURE;
                        end else begin
                            r_state    <= c_ST_DROP;
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_CAPTURE: begin
                    if (in_valid) begin
                        if (w_last) begin
                            r_state <= c_ST_COMMIT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end else begin
                        r_short_err <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                c_ST_DROP: begin
                    if (in_valid && !w_last) begin
                        r_cnt <= r_cnt + AW'(1);
                    end else begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    fft_frame_bank #(
        .WIDTH  (WIDTH),
        .NPOINT (NPOINT),
        .AW     (AW)
    ) u_bank (
        .clk       (clk),
        .i_rst_n   (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (w_tgt_bank),
        .i_wr_addr (w_waddr),
        .i_wr_data ({in_re, in_im}),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign rd_re       = w_rd_data[2*WIDTH-1:WIDTH];
    assign rd_im       = w_rd_data[WIDTH-1:0];
    assign frame_ready = (r_full[r_rd_bank] == c_BANK_FULL);
    assign frame_done  = (r_state == c_ST_COMMIT);
    assign busy        = (r_state != c_ST_IDLE);
    assign overflow    = r_overflow;
    assign short_err   = r_short_err;

endmodule

`default_nettype wire

// File: tb/tb_fft_stream_collector.sv
// ============================================================================
// Module : tb_fft_stream_collector
// Brief  : Directed scoreboard bench for fft_stream_collector
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_stream_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic [2:0]  rd_addr;
    logic        rd_release;

    logic [15:0] rd_re,  rd_im;
    logic        frame_ready, frame_done, busy, overflow, short_err;
    logic [15:0] rv_re,  rv_im;
    logic        rv_ready, rv_done, rv_busy, rv_ovf, rv_short;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    fft_stream_collector #(.WIDTH(16), .NPOINT(8), .AW(3), .REVERSE(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_re(rd_re), .rd_im(rd_im),
        .frame_ready(frame_ready), .frame_done(frame_done), .busy(busy),
        .overflow(overflow), .short_err(short_err)
    );

    fft_stream_collector #(.WIDTH(16), .NPOINT(8), .AW(3), .REVERSE(1)) u_rev (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_re(rv_re), .rd_im(rv_im),
        .frame_ready(rv_ready), .frame_done(rv_done), .busy(rv_busy),
        .overflow(rv_ovf), .short_err(rv_short)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_words(input int base, input int n);
        logic [15:0] v;
        for (int k = 0; k < n; k++) begin
            v        = 16'(base + k + 1);
            in_valid = 1'b1;
            in_re    = v;
            in_im    = 16'd0 - v;
            @(negedge clk);
        end
    endtask

    task automatic push_frame(input int base);
        logic [15:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 16'(base + k + 1);
            q.push_back({v, 16'd0 - v});
        end
    endtask

    task automatic read_frame(input string tag);
        logic [31:0] exp;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            @(negedge clk);
            exp = 32'hDEAD_BEEF;
            if (q.size() > 0) exp = q.pop_front();
            chk(tag, {rd_re, rd_im}, exp);
            chk({tag, "_ready"}, {31'd0, frame_ready}, 32'd1);
        end
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        rd_addr = '0; rd_release = 1'b0;
        @(negedge clk); @(negedge clk);

        // 1: reset values, then reset mid-capture
        chk("rst_outs", {rd_re, rd_im}, 32'd0);
        chk("rst_flags", {27'd0, frame_ready, frame_done, busy, overflow, short_err}, 32'd0);
        rst = 1'b1;
        drive_words(100, 4);
        chk("midcap_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst2_flags", {27'd0, frame_ready, frame_done, busy, overflow, short_err}, 32'd0);
        chk("rst2_rd", {rd_re, rd_im}, 32'd0);
        rst = 1'b1;

        // 2: single frame A
        push_frame(0);
        drive_words(0, 8);
        chk("A_done", {30'd0, frame_done, frame_ready}, 32'd2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("A_after", {30'd0, frame_done, frame_ready}, 32'd1);
        rd_addr = 3'd3;
        @(negedge clk);
        chk("A_addr3", {rd_re, rd_im}, {16'd4, 16'hFFFC});
        chk("A_rev_addr3", {rv_re, rv_im}, {16'd5, 16'hFFFB});
        read_frame("A_read");
        release_bank();
        chk("A_rel_ready", {31'd0, frame_ready}, 32'd0);

        // 3: back-to-back frames B, C
        push_frame(10);
        push_frame(20);
        drive_words(10, 8);
        chk("B_done", {31'd0, frame_done}, 32'd1);
        drive_words(20, 8);
        chk("C_done", {31'd0, frame_done}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("BC_busy", {31'd0, busy}, 32'd0);
        read_frame("B_read");
        release_bank();
        chk("BC_toggle_ready", {31'd0, frame_ready}, 32'd1);

        // 4: D fills the free bank, E overflows
        push_frame(30);
        drive_words(30, 8);
        chk("D_done", {31'd0, frame_done}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        drive_words(40, 8);
        chk("E_nodone", {31'd0, frame_done}, 32'd0);
        chk("E_ovf", {31'd0, overflow}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        read_frame("C_read");
        release_bank();
        read_frame("D_read");
        release_bank();
        chk("D_rel_ready", {31'd0, frame_ready}, 32'd0);

        // 5: short frame then full frame F
        drive_words(50, 5);
        in_valid = 1'b0;
        @(negedge clk);
        chk("short_err", {30'd0, short_err, frame_ready}, 32'd2);
        chk("short_busy", {31'd0, busy}, 32'd0);
        push_frame(60);
        drive_words(60, 8);
        chk("F_done", {31'd0, frame_done}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        read_frame("F_read");

        // 6: release coincident with COMMIT of G, then H
        push_frame(70);
        drive_words(70, 8);
        chk("G_done", {30'd0, frame_done, frame_ready}, 32'd3);
        in_valid = 1'b0;
        release_bank();
        chk("G_ready", {31'd0, frame_ready}, 32'd1);
        push_frame(80);
        drive_words(80, 8);
        chk("H_done", {30'd0, frame_done, frame_ready}, 32'd3);
        in_valid = 1'b0;
        @(negedge clk);
        read_frame("G_read");
        release_bank();
        chk("H_ready", {31'd0, frame_ready}, 32'd1);
        read_frame("H_read");
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
